ofifo_flex: RTL and testbench
=============================

Name: ofifo_flex

Overview:
Parametrised per-column output FIFO that collects PE-array column results, where each column writes independently.
- Depth, lane width and column count are generic.
- Storage is internal; no external FIFO macro is used.
- Two drain modes: row mode pops all columns at once; lane mode pops one column per read, round-robin.
- Adds almost-full, per-lane occupancy, a registered read-data valid, and sticky overflow/underflow flags.
- Sits between the array's column outputs and the SFU/SRAM writeback path.

Parameters:
col, 8, number of columns/lanes
bw, 4, bits per lane entry
depth, 64, entries per lane; power of 2, >=4
af_thresh, 60, o_afull asserts when any lane count >= af_thresh; 1..depth
cw, 7, count width = log2(depth)+1

Ports:
clk  in  1  clock
reset  in  1  reset
in  in  col*bw  write data; lane i = in[bw*(i+1)-1:bw*i]
wr  in  col  per-lane write enable
rd  in  1  read request
mode  in  1  0 = row drain, 1 = lane drain
out  out  col*bw  read data (registered)
o_rvalid  out  1  out holds newly popped data this cycle
o_valid  out  1  a read would be accepted now
o_ready  out  1  at least one lane not full
o_full  out  1  any lane full
o_afull  out  1  any lane count >= af_thresh
o_cnt_min  out  cw  minimum occupancy over all lanes
o_ovf  out  1  sticky: a write was dropped
o_udf  out  1  sticky: rd was asserted while o_valid=0

Behaviour:
- Reset (reset, synchronous, active-high; clock clk): pointers, counts and lane select sel cleared to 0; out=0, o_rvalid=0, o_ovf=0, o_udf=0. Memory contents are don't-care.
- Reset has priority over rd/wr in the same cycle; reset mid-drain discards all data.
- Per lane: wptr, rptr (log2(depth) bits, wrap naturally) and count (0..depth).
- Write lane i: accepted iff wr[i] and (count_i<depth, or a read of lane i is accepted the same cycle).
  - Rejected write: data dropped, o_ovf<=1.
- Row mode (mode=0):
  - o_valid = all counts >0.
  - rd && o_valid pops one entry from every lane; next cycle out = all lane heads, o_rvalid=1.
- Lane mode (mode=1):
  - o_valid = count_sel>0.
  - rd && o_valid pops lane sel; next cycle out[bw-1:0] = that entry, upper bits 0, o_rvalid=1.
  - sel <= (sel==col-1) ? 0 : sel+1, advancing only on an accepted read.
- Read latency: 1 cycle from accepted rd to o_rvalid.
  - out holds its last value when no read is accepted; o_rvalid=0 on those cycles.
- rd with o_valid=0: ignored, no state change, o_udf<=1.
- Simultaneous read and write on one lane:
  - Both take effect; count unchanged.
  - A write into an empty lane is not readable until the next cycle (count=0 blocks the same-cycle read).
- mode is sampled each cycle. Any change of mode versus the previous cycle forces sel<=0; a read in that cycle uses the new mode with sel=0.
- Flags are combinational from current counts:
  - o_full = OR(count_i==depth)
  - o_ready = NOT AND(count_i==depth)
  - o_afull = OR(count_i>=af_thresh)
  - o_cnt_min = min over i of count_i
- o_ovf/o_udf clear only on reset.

Test Plan:
1. Reset, then wr=8'hFF for 3 cycles with lane i data = i+cycle; mode=0, rd 3 cycles -> o_rvalid on cycles 1..3 after each rd; out lanes = {7..0}+0,+1,+2; then o_valid=0, o_cnt_min=0.
2. Write only lane 0 five times; rd in mode 0 -> o_valid=0, no o_rvalid, o_udf=1; o_cnt_min=0, o_ready=1.
3. Fill lane 3 with 64 writes -> o_full=1, o_afull asserted from count 60; 65th write -> dropped, o_ovf=1, count stays 64; write+row-read same cycle with all lanes full -> write accepted, count stays 64.
4. Mode 1, one entry per lane (lane i = i), 10 consecutive rd -> out[3:0] = 0,1,...,7 on successive cycles; then 2 rd with o_valid=0 -> o_udf=1, sel=0.
5. Mode 1, pop 3 lanes, toggle mode to 0 and back to 1 -> next lane-mode read returns lane 0 data (sel reset).
6. Wrap: 200 cycles of continuous wr=all and rd in mode 0 after 2-entry prefill -> data in order, counts steady at 2, no ovf/udf; assert reset mid-stream -> next cycle counts 0, o_rvalid=0, out=0.

Source files
------------

// File: rtl/ofifo_flex.sv
// Per-column output FIFO for PE-array results: independent lane writes,
// row drain (all lanes at once) or lane drain (one lane per read, round-robin).
module ofifo_flex #(
   parameter int unsigned col       = 8,
   parameter int unsigned bw        = 4,
   parameter int unsigned depth     = 64,
   parameter int unsigned af_thresh = 60,
   parameter int unsigned cw        = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [col*bw-1:0] in,
   input  logic [col-1:0]    wr,
   input  logic              rd,
   input  logic              mode,
   output logic [col*bw-1:0] out,
   output logic              o_rvalid,
   output logic              o_valid,
   output logic              o_ready,
   output logic              o_full,
   output logic              o_afull,
   output logic [cw-1:0]     o_cnt_min,
   output logic              o_ovf,
   output logic              o_udf
);

   localparam int unsigned aw = $clog2(depth);
   localparam int unsigned sw = (col > 1) ? $clog2(col) : 1;

   logic [bw-1:0]     mem [col][depth];
   logic [aw-1:0]     wptr [col];
   logic [aw-1:0]     rptr [col];
   logic [cw-1:0]     cnt  [col];
   logic [sw-1:0]     sel, eff_sel, sel_nxt;
   logic              mode_q, mode_chg, rd_acc;
   logic [col-1:0]    pop, wr_acc, nonempty, full_vec, af_vec;
   logic [col*bw-1:0] rd_data;

   // Lane status, read/write acceptance and lane-select sequencing
   always_comb begin
      mode_chg = (mode != mode_q);
      eff_sel  = mode_chg ? '0 : sel;
      for (int unsigned i = 0; i < col; i++) begin
         nonempty[i] = (cnt[i] != '0);
         full_vec[i] = (cnt[i] == cw'(depth));
         af_vec[i]   = (cnt[i] >= cw'(af_thresh));
      end
      o_valid = mode ? nonempty[eff_sel] : (&nonempty);
      rd_acc  = rd & o_valid;
      for (int unsigned i = 0; i < col; i++) begin
         pop[i]    = rd_acc & (~mode | (sw'(i) == eff_sel));
         // a full lane still accepts a write when it is popped this cycle
         wr_acc[i] = wr[i] & (~full_vec[i] | pop[i]);
      end
      sel_nxt = eff_sel;
      if (rd_acc && mode)
         sel_nxt = (eff_sel == sw'(col - 1)) ? '0 : eff_sel + sw'(1);
   end

   // Occupancy flags
   always_comb begin
      o_full    = |full_vec;
      o_ready   = ~(&full_vec);
      o_afull   = |af_vec;
      o_cnt_min = cnt[0];
      for (int unsigned i = 1; i < col; i++)
         if (cnt[i] < o_cnt_min) o_cnt_min = cnt[i];
   end

   // Read data: all lane heads, or the selected lane head in the low lane
   always_comb begin
      rd_data = '0;
      if (mode) begin
         rd_data[bw-1:0] = mem[eff_sel][rptr[eff_sel]];
      end else begin
         for (int unsigned i = 0; i < col; i++)
            rd_data[bw*i +: bw] = mem[i][rptr[i]];
      end
   end

   // Storage array; contents are not reset
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < col; i++)
         if (wr_acc[i]) mem[i][wptr[i]] <= in[bw*i +: bw];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < col; i++) begin
            wptr[i] <= '0;
            rptr[i] <= '0;
            cnt[i]  <= '0;
         end
         sel      <= '0;
         mode_q   <= 1'b0;
         out      <= '0;
         o_rvalid <= 1'b0;
         o_ovf    <= 1'b0;
         o_udf    <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < col; i++) begin
            if (wr_acc[i]) wptr[i] <= wptr[i] + aw'(1);
            if (pop[i])    rptr[i] <= rptr[i] + aw'(1);
            case ({wr_acc[i], pop[i]})
               2'b10:   cnt[i] <= cnt[i] + cw'(1);
               2'b01:   cnt[i] <= cnt[i] - cw'(1);
               default: cnt[i] <= cnt[i];
            endcase
         end
         sel      <= sel_nxt;
         mode_q   <= mode;
         o_rvalid <= rd_acc;
         if (rd_acc) out <= rd_data;
         if (|(wr & ~wr_acc)) o_ovf <= 1'b1;
         if (rd && !o_valid)  o_udf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ofifo_flex.sv
// Scoreboard bench for ofifo_flex: directed stimulus pushes expected read data,
// an independent monitor pops and compares on every o_rvalid.
module tb_ofifo_flex;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in;
   logic [7:0]  wr;
   logic        rd;
   logic        mode;
   logic [31:0] out;
   logic        o_rvalid, o_valid, o_ready, o_full, o_afull, o_ovf, o_udf;
   logic [6:0]  o_cnt_min;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   ofifo_flex #(.col(8), .bw(4), .depth(64), .af_thresh(60), .cw(7)) dut (
      .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .mode(mode),
      .out(out), .o_rvalid(o_rvalid), .o_valid(o_valid), .o_ready(o_ready),
      .o_full(o_full), .o_afull(o_afull), .o_cnt_min(o_cnt_min),
      .o_ovf(o_ovf), .o_udf(o_udf)
   );

   always #5 clk = ~clk;

   // lane i holds (b+i) mod 16
   function automatic logic [31:0] row_word(input int b);
      logic [31:0] r;
      for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'((b + i) % 16);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; rd = 1'b0; wr = '0;
      tick();
      reset = 1'b0;
   endtask

   // Monitor: every presented read result must match the oldest expectation
   always @(negedge clk) begin
      if (o_rvalid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rdata_unexpected: got %0h expected no o_rvalid", out);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (out !== e) begin
               errors++;
               $display("FAIL rdata: got %0h expected %0h", out, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; in = '0; wr = '0; rd = 1'b0; mode = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // 1: reset state, row writes and row drain
      chk("rst_out", out, 0);
      chk("rst_rvalid", o_rvalid, 0);
      chk("rst_ovf", o_ovf, 0);
      chk("rst_udf", o_udf, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_cnt_min", o_cnt_min, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_full", o_full, 0);
      for (int c = 0; c < 3; c++) begin
         in = row_word(c); wr = 8'hFF;
         tick();
      end
      wr = '0;
      chk("t1_cnt_min3", o_cnt_min, 3);
      chk("t1_valid", o_valid, 1);
      chk("t1_afull", o_afull, 0);
      rd = 1'b1;
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(row_word(c));
         tick();
      end
      rd = 1'b0;
      chk("t1_valid_empty", o_valid, 0);
      chk("t1_cnt_min0", o_cnt_min, 0);
      tick();

      // 2: one lane populated, row read refused
      for (int c = 0; c < 5; c++) begin
         in = 32'(c); wr = 8'h01;
         tick();
      end
      wr = '0;
      chk("t2_valid", o_valid, 0);
      rd = 1'b1;
      tick();
      rd = 1'b0;
      chk("t2_udf", o_udf, 1);
      chk("t2_cnt_min", o_cnt_min, 0);
      chk("t2_ready", o_ready, 1);
      tick();
      do_reset();
      chk("t2_udf_cleared", o_udf, 0);

      // 3: fill lane 3, overflow, then full write+read
      for (int k = 1; k <= 64; k++) begin
         in = {8{4'((k - 1) % 16)}}; wr = 8'h08;
         tick();
         chk("t3_afull", o_afull, (k >= 60) ? 1 : 0);
         chk("t3_full", o_full, (k == 64) ? 1 : 0);
      end
      chk("t3_ready_one_full", o_ready, 1);
      chk("t3_ovf_before", o_ovf, 0);
      in = 32'hFFFF_FFFF; wr = 8'h08;
      tick();
      chk("t3_ovf", o_ovf, 1);
      chk("t3_full_after_drop", o_full, 1);
      for (int k = 1; k <= 64; k++) begin
         in = {8{4'((k - 1) % 16)}}; wr = 8'hF7;
         tick();
      end
      wr = '0;
      chk("t3_all_full_ready", o_ready, 0);
      chk("t3_all_full_cnt", o_cnt_min, 64);
      in = {8{4'h5}}; wr = 8'hFF; rd = 1'b1;
      exp_q.push_back(32'h0);
      tick();
      wr = '0; rd = 1'b0;
      chk("t3_wr_rd_full_cnt", o_cnt_min, 64);
      chk("t3_wr_rd_full", o_full, 1);
      tick();
      do_reset();

      // 4: lane drain round-robin, underflow, sel wraps to 0
      in = row_word(0); wr = 8'hFF; mode = 1'b0;
      tick();
      wr = '0; mode = 1'b1; rd = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) exp_q.push_back(32'(i));
         tick();
      end
      rd = 1'b0;
      chk("t4_udf", o_udf, 1);
      in = row_word(8); wr = 8'hFF;
      tick();
      wr = '0; rd = 1'b1;
      exp_q.push_back(32'h8);
      tick();
      rd = 1'b0;
      tick();
      do_reset();

      // 5: mode toggle resets lane select
      mode = 1'b1;
      in = row_word(0); wr = 8'hFF;
      tick();
      in = row_word(8);
      tick();
      wr = '0; rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'(i));
         tick();
      end
      rd = 1'b0; mode = 1'b0;
      tick();
      mode = 1'b1; rd = 1'b1;
      exp_q.push_back(32'h8);
      tick();
      rd = 1'b0;
      tick();
      do_reset();
      mode = 1'b0;

      // 6: pointer wrap under steady streaming, then reset mid-stream
      for (int v = 0; v < 2; v++) begin
         in = row_word(v); wr = 8'hFF;
         tick();
      end
      rd = 1'b1;
      for (int v = 2; v < 202; v++) begin
         in = row_word(v); wr = 8'hFF;
         exp_q.push_back(row_word(v - 2));
         tick();
         if (v % 20 == 0) chk("t6_cnt_steady", o_cnt_min, 2);
      end
      chk("t6_ovf", o_ovf, 0);
      chk("t6_udf", o_udf, 0);
      @(negedge clk);
      #1;
      reset = 1'b1;
      tick();
      chk("t6_rst_cnt", o_cnt_min, 0);
      chk("t6_rst_rvalid", o_rvalid, 0);
      chk("t6_rst_out", out, 0);
      chk("t6_rst_valid", o_valid, 0);
      reset = 1'b0; rd = 1'b0; wr = '0;
      tick(); tick();

      chk("scoreboard_drained", 64'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
